// File: rtl/ext_link_pkg.sv
// Shared definitions for the inter-board external link (receiver and transmitter).
package ext_link_pkg;

  // Payload width of one link frame.
  localparam int DATA_BITS = 8;

  // 50 MHz system clock divided down to 9600 baud.
  localparam int CLKS_PER_BIT_DEF = 5208;

  // Receiver FSM states; the encodings are also shown on the debug LEDs.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_ACK     = 3'd4,
    ST_RECOVER = 3'd5
  } link_state_e;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous level, with a selectable reset value.
module bit_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next-state of the two synchronizer stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops; both stages start at the idle level.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ext_link_rx.sv
// External-link serial receiver: 8N1 frame decode, valid/ready byte output and ack to the sender.
module ext_link_rx
  import ext_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int ACK_BITS     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 receiver_en,
  input  logic                 ext_data_in,
  output logic                 ack_out,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 tick,
  output logic [2:0]           state_rx
);

  // One counter serves bit timing and the (longer) ack phase.
  localparam int ACK_CYCLES = ACK_BITS * CLKS_PER_BIT;
  localparam int CW         = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;

  localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] CNT_HALF    = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ACK_END = CW'(ACK_CYCLES - 1);

  localparam logic [2:0] BIDX_ZERO = 3'd0;
  localparam logic [2:0] BIDX_ONE  = 3'd1;
  localparam logic [2:0] BIDX_LAST = 3'(DATA_BITS - 1);

  logic sd;

  link_state_e          state_q,    state_d;
  logic [CW-1:0]        cnt_q,      cnt_d;
  logic [2:0]           bidx_q,     bidx_d;
  logic [DATA_BITS-1:0] shreg_q,    shreg_d;
  logic [DATA_BITS-1:0] rx_data_q,  rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 ack_q,      ack_d;
  logic                 ferr_q,     ferr_d;
  logic                 overrun_q,  overrun_d;
  logic                 tick_q,     tick_d;

  bit_sync #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (ext_data_in),
    .q    (sd)
  );

  // Frame FSM, bit timing, byte assembly, handshake and status flags.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bidx_d     = bidx_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    // A byte is consumed whenever the consumer takes it, independent of the FSM.
    rx_valid_d = rx_valid_q & ~rx_ready;
    ack_d      = 1'b0;
    ferr_d     = 1'b0;
    overrun_d  = overrun_q;
    tick_d     = 1'b0;

    if (!receiver_en) begin
      // Disabled: abort any frame, keep the delivered byte and the sticky flag.
      state_d = ST_IDLE;
      cnt_d   = CNT_ZERO;
      bidx_d  = BIDX_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d  = CNT_ZERO;
          bidx_d = BIDX_ZERO;
          if (!sd) begin
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_START: begin
          if (cnt_q == CNT_HALF) begin
            // Mid start bit: a line back high here was only a glitch.
            tick_d = 1'b1;
            cnt_d  = CNT_ZERO;
            bidx_d = BIDX_ZERO;
            if (!sd) begin
              state_d = ST_DATA;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_DATA: begin
          if (cnt_q == CNT_BIT_END) begin
            // One full bit after the previous mid-bit point: sample, LSB first.
            tick_d          = 1'b1;
            cnt_d           = CNT_ZERO;
            shreg_d[bidx_q] = sd;
            if (bidx_q == BIDX_LAST) begin
              bidx_d  = BIDX_ZERO;
              state_d = ST_STOP;
            end else begin
              bidx_d = bidx_q + BIDX_ONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_STOP: begin
          if (cnt_q == CNT_BIT_END) begin
            tick_d = 1'b1;
            cnt_d  = CNT_ZERO;
            if (sd) begin
              if (!rx_valid_q || rx_ready) begin
                // Output slot free (or freed this very cycle): deliver and acknowledge.
                rx_data_d  = shreg_q;
                rx_valid_d = 1'b1;
                ack_d      = 1'b1;
                state_d    = ST_ACK;
              end else begin
                // Previous byte still pending: drop this one and withhold the ack.
                overrun_d = 1'b1;
                state_d   = ST_IDLE;
              end
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_RECOVER;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_ACK: begin
          if (cnt_q == CNT_ACK_END) begin
            ack_d   = 1'b0;
            cnt_d   = CNT_ZERO;
            state_d = ST_IDLE;
          end else begin
            ack_d = 1'b1;
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_RECOVER: begin
          // Hold off until the line is idle so a break cannot look like a start bit.
          cnt_d = CNT_ZERO;
          if (sd) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RECOVER;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
          bidx_d  = BIDX_ZERO;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= CNT_ZERO;
      bidx_q     <= BIDX_ZERO;
      shreg_q    <= {DATA_BITS{1'b0}};
      rx_data_q  <= {DATA_BITS{1'b0}};
      rx_valid_q <= 1'b0;
      ack_q      <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bidx_q     <= bidx_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ack_q      <= ack_d;
      ferr_q     <= ferr_d;
      overrun_q  <= overrun_d;
      tick_q     <= tick_d;
    end
  end

  assign ack_out   = ack_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = ferr_q;
  assign overrun   = overrun_q;
  assign tick      = tick_q;
  assign state_rx  = state_q;

endmodule
